// File: rtl/build_deck_pkg.sv
// Shared card definitions: node word layout, null pointer, deck geometry and
// the controller state encoding.
package build_deck_pkg;
  localparam int ADDR_W        = 10;
  localparam int WORD_W        = 32;
  localparam int CNT_W         = 11;
  localparam int DECK_SIZE_DEF = 52;
  localparam int SUIT_CARDS    = 13;

  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

  // Bit positions follow declaration order: [31] alloc ... [9:0] next.
  typedef struct packed {
    logic              alloc;
    logic [3:0]        value;
    logic [1:0]        suit;
    logic [14:0]       rsvd;
    logic [ADDR_W-1:0] next;
  } node_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_BUILD, S_VERIFY, S_DRAIN, S_DONE
  } state_t;
endpackage

// File: rtl/build_deck_if.sv
// Single-port RAM bus between the deck builder and its node memory.
interface build_deck_if;
  logic [build_deck_pkg::ADDR_W-1:0] address;
  logic [build_deck_pkg::WORD_W-1:0] data;
  logic                              wren;
  logic [build_deck_pkg::WORD_W-1:0] q;

  modport master (output address, data, wren, input  q);
  modport slave  (input  address, data, wren, output q);
endinterface

// File: rtl/build_deck_ctrl.sv
// Clear / build / verify sequencer driving the node RAM through the bus
// interface. RAM outputs are decoded from state so reset forces them to 0.
module build_deck_ctrl import build_deck_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 10'd1,
  parameter int                DECK_SIZE   = DECK_SIZE_DEF,
  parameter int                CLEAR_WORDS = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] head_addr,
  build_deck_if.master      ram
);
  state_t           state, nstate;
  logic [CNT_W-1:0] cnt, idx, pack_k;
  logic [1:0]       vld_pipe;
  logic             miss, start_acc;
  node_t            node;

  // One packer: BUILD feeds the live count, compares feed the delayed index.
  assign pack_k = (state == S_BUILD) ? cnt : idx;

  card_node_pack #(.BASE_ADDR(BASE_ADDR), .DECK_SIZE(DECK_SIZE)) u_pack (
    .k    (pack_k),
    .node (node)
  );

  assign start_acc = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign head_addr = done ? BASE_ADDR : NULL_ADDR;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      vld_pipe <= '0;
      miss     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= nstate;
      if (nstate != state) cnt <= '0;
      else if (busy)       cnt <= cnt + CNT_W'(1);
      // Read issued at stage 0 returns data a cycle later; the mismatch is
      // registered and folded into error one more cycle on.
      idx         <= cnt;
      vld_pipe[0] <= (state == S_VERIFY);
      miss        <= vld_pipe[0] && (ram.q != WORD_W'(node));
      vld_pipe[1] <= vld_pipe[0];
      if (start_acc)                error <= 1'b0;
      else if (vld_pipe[1] && miss) error <= 1'b1;
    end
  end

  always_comb begin
    nstate      = state;
    ram.address = '0;
    ram.data    = '0;
    ram.wren    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) nstate = S_CLEAR;
      S_CLEAR: begin
        ram.address = ADDR_W'(cnt);
        ram.wren    = 1'b1;
        if (cnt == CNT_W'(CLEAR_WORDS - 1)) nstate = S_BUILD;
      end
      S_BUILD: begin
        ram.address = BASE_ADDR + ADDR_W'(cnt);
        ram.data    = WORD_W'(node);
        ram.wren    = 1'b1;
        if (cnt == CNT_W'(DECK_SIZE - 1)) nstate = S_VERIFY;
      end
      S_VERIFY: begin
        ram.address = BASE_ADDR + ADDR_W'(cnt);
        if (cnt == CNT_W'(DECK_SIZE - 1)) nstate = S_DRAIN;
      end
      // Two cycles: last compare, then last error fold.
      S_DRAIN: if (cnt == CNT_W'(1)) nstate = S_DONE;
      default: nstate = S_IDLE;
    endcase
  end
endmodule

// File: rtl/card_node_pack.sv
// Maps a card index k to its fully formed node word.
module card_node_pack import build_deck_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 10'd1,
  parameter int                DECK_SIZE = DECK_SIZE_DEF
) (
  input  logic [CNT_W-1:0] k,
  output node_t            node
);
  always_comb begin
    node       = '0;
    node.alloc = 1'b1;
    node.value = 4'(k % 11'd13) + 4'd1;
    node.suit  = 2'(k / 11'd13);
    node.next  = (k == CNT_W'(DECK_SIZE - 1)) ? NULL_ADDR
                                              : BASE_ADDR + ADDR_W'(k) + ADDR_W'(1);
  end
endmodule

// File: rtl/build_deck.sv
// Builds a 52-card singly linked deck in an external RAM: clear, write, verify.
module build_deck import build_deck_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 10'd1,
  parameter int                DECK_SIZE   = DECK_SIZE_DEF,
  parameter int                CLEAR_WORDS = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] head_addr,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clock,
  output logic [WORD_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [WORD_W-1:0] ram_q
);
  build_deck_if ram_bus ();

  build_deck_ctrl #(
    .BASE_ADDR   (BASE_ADDR),
    .DECK_SIZE   (DECK_SIZE),
    .CLEAR_WORDS (CLEAR_WORDS)
  ) u_ctrl (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .head_addr (head_addr),
    .ram       (ram_bus)
  );

  assign ram_address = ram_bus.address;
  assign ram_data    = ram_bus.data;
  assign ram_wren    = ram_bus.wren;
  assign ram_bus.q   = ram_q;
  assign ram_clock   = clock;
endmodule

// File: tb/tb_build_deck.sv
// Directed bench for build_deck with a 1-cycle-latency RAM model.
module tb_build_deck;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error, ram_clock;
  logic [9:0] head_addr;

  logic        pre_en = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic        corrupt = 1'b0;
  logic [31:0] mem [0:1023];

  int tests = 0;
  int fails = 0;

  build_deck_if bus ();

  build_deck dut (
    .clock       (clk),
    .resetn      (resetn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .head_addr   (head_addr),
    .ram_address (bus.address),
    .ram_clock   (ram_clock),
    .ram_data    (bus.data),
    .ram_wren    (bus.wren),
    .ram_q       (bus.q)
  );

  always #5 clk = ~clk;

  always @(posedge ram_clock) begin
    if (pre_en)        mem[pre_addr]    <= pre_data;
    else if (bus.wren) mem[bus.address] <= bus.data;
    if (corrupt && !bus.wren && bus.address == 10'd20)
      bus.q <= mem[bus.address] ^ 32'h0000_0100;
    else
      bus.q <= mem[bus.address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},  {31'd0, busy},      32'd0);
    check({tag, " done"},  {31'd0, done},      32'd0);
    check({tag, " error"}, {31'd0, error},     32'd0);
    check({tag, " head"},  {22'd0, head_addr}, 32'd0);
    check({tag, " wren"},  {31'd0, bus.wren},  32'd0);
    check({tag, " addr"},  {22'd0, bus.address}, 32'd0);
    check({tag, " data"},  bus.data,           32'd0);
  endtask

  // Raise start, pass the accepting edge, then count edges until done.
  task automatic do_run(input bit hold, output int n, output logic b0, output logic e0,
                        output logic d0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    b0 = busy; e0 = error; d0 = done;
    if (!hold) start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    int n, walk;
    logic b0, e0, d0;
    logic [9:0] p;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk); resetn = 1'b1;

    // Dirty a cleared-region word before the first run
    @(negedge clk); pre_en = 1'b1; pre_addr = 10'd500; pre_data = 32'hFFFF_FFFF;
    @(negedge clk); pre_en = 1'b0;
    check("idle_wren", {31'd0, bus.wren}, 32'd0);

    // Run 1: nominal
    do_run(1'b0, n, b0, e0, d0);
    check("run1 busy_after_start", {31'd0, b0}, 32'd1);
    check("run1 cycles", n, 32'd1130);
    check("run1 error", {31'd0, error}, 32'd0);
    check("run1 head", {22'd0, head_addr}, 32'd1);
    check("run1 busy_in_done", {31'd0, busy}, 32'd0);
    check("run1 wren_in_done", {31'd0, bus.wren}, 32'd0);
    check("ram1", mem[1], 32'h8800_0002);
    check("ram14", mem[14], 32'h8A00_000F);
    check("ram52", mem[52], 32'hEE00_0000);
    check("ram500", mem[500], 32'h0000_0000);
    check("ram0", mem[0], 32'h0000_0000);
    check("ram53", mem[53], 32'h0000_0000);

    // Walk the list from head
    p = head_addr; walk = 0;
    while (p != 10'd0 && walk < 100) begin
      p = mem[p][9:0]; walk++;
    end
    check("walk nodes", walk, 32'd52);
    check("walk end", {22'd0, p}, 32'd0);

    // Run 2: RAM returns a corrupted word for address 20
    corrupt = 1'b1;
    do_run(1'b0, n, b0, e0, d0);
    corrupt = 1'b0;
    check("corrupt cycles", n, 32'd1130);
    check("corrupt error", {31'd0, error}, 32'd1);

    // Run 3: error and done clear on the accepting edge
    do_run(1'b0, n, b0, e0, d0);
    check("rerun error_cleared", {31'd0, e0}, 32'd0);
    check("rerun done_cleared", {31'd0, d0}, 32'd0);
    check("rerun cycles", n, 32'd1130);
    check("rerun error", {31'd0, error}, 32'd0);

    // Run 4: start held high throughout
    do_run(1'b1, n, b0, e0, d0);
    check("hold cycles", n, 32'd1130);
    check("hold done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("hold restart busy", {31'd0, busy}, 32'd1);
    check("hold restart done", {31'd0, done}, 32'd0);
    start = 1'b0;
    wait_done(n);
    check("hold second cycles", n, 32'd1130);

    // Run 5: reset dropped mid-BUILD (card 6 -> address 7)
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (1030) @(posedge clk);
    #1;
    check("midbuild wren", {31'd0, bus.wren}, 32'd1);
    check("midbuild addr", {22'd0, bus.address}, 32'd7);
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk); resetn = 1'b1;
    do_run(1'b0, n, b0, e0, d0);
    check("postreset cycles", n, 32'd1130);
    check("postreset error", {31'd0, error}, 32'd0);
    check("postreset ram52", mem[52], 32'hEE00_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
